// File: rtl/power_bcd_unit_if.sv
// Start/busy/done handshake and display bus for power_bcd_unit.
// The master drives the request side. The slave is the unit itself.
interface power_bcd_unit_if #(
  parameter int XW     = 5,
  parameter int EW     = 3,
  parameter int DIGITS = 6
) ();
  logic                  start;
  logic [XW-1:0]         operandX;
  logic [EW-1:0]         exponent;
  logic                  hidden;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   digits;

  modport master (output start, operandX, exponent, hidden,
                  input  busy, done, overflow, digits);
  modport slave  (input  start, operandX, exponent, hidden,
                  output busy, done, overflow, digits);
endinterface

// File: rtl/power_bcd_unit.sv
// X^E by iterative multiply, followed by a serial double-dabble conversion to DIGITS BCD digits.
// Latency is E+RW cycles from the accepting edge. It does not depend on X or on overflow.
module power_bcd_unit #(
  parameter int XW     = 5,
  parameter int DIGITS = 6,
  parameter int RW     = 20,
  parameter int EW     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  power_bcd_unit_if.slave  bus
);
  localparam int PW = RW + XW;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(RW + (1 << EW)) + 1;

  function automatic logic [PW-1:0] pow10(input int n);
    logic [PW-1:0] r;
    r = PW'(1);
    for (int i = 0; i < n; i++) r = r * PW'(10);
    return r;
  endfunction

  localparam logic [PW-1:0] LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {IDLE, MUL, CONV, DONE} state_t;

  state_t          st;
  logic [XW-1:0]   x_q;
  logic [RW-1:0]   acc;
  logic [BW-1:0]   bcd, bcd_adj, bcd_nxt, dig_q;
  logic [CW-1:0]   cnt;
  logic            ovf, busy_q, done_q, ovf_q;
  logic [PW-1:0]   prod;

  assign prod = PW'(acc) * PW'(x_q);

  // Add-3 on every nibble >= 5, then shift in the next acc bit, MSB first.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end
  assign bcd_nxt = {bcd_adj[BW-2:0], acc[RW-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      x_q    <= '0;
      acc    <= '0;
      bcd    <= '0;
      dig_q  <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.start) begin
          x_q    <= bus.operandX;
          acc    <= RW'(1);
          bcd    <= '0;
          ovf    <= 1'b0;
          ovf_q  <= 1'b0;
          busy_q <= 1'b1;
          if (bus.exponent == '0) begin
            st  <= CONV;
            cnt <= CW'(RW);
          end else begin
            st  <= MUL;
            cnt <= CW'(bus.exponent);
          end
        end
        MUL: begin
          // Once overflowed, acc stays frozen. Only the flag matters from here on.
          if (!ovf) begin
            if (prod >= LIMIT) ovf <= 1'b1;
            else               acc <= prod[RW-1:0];
          end
          if (cnt == CW'(1)) begin
            st  <= CONV;
            cnt <= CW'(RW);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        CONV: begin
          bcd <= bcd_nxt;
          acc <= {acc[RW-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            st     <= DONE;
            dig_q  <= ovf ? {DIGITS{4'hE}} : bcd_nxt;
            ovf_q  <= ovf;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.digits   = bus.hidden ? {DIGITS{4'hF}} : dig_q;
endmodule

// File: tb/tb_power_bcd_unit.sv
// Directed checks of power_bcd_unit in its default configuration (w=0).
// A second instance with XW=8, DIGITS=4, RW=14 (w=1) covers the parameter sweep.
module tb_power_bcd_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  power_bcd_unit_if #(.XW(5), .EW(3), .DIGITS(6)) b1 ();
  power_bcd_unit_if #(.XW(8), .EW(3), .DIGITS(4)) b2 ();

  power_bcd_unit #(.XW(5), .DIGITS(6), .RW(20), .EW(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  power_bcd_unit #(.XW(8), .DIGITS(4), .RW(14), .EW(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer power, then decimal digits by division.
  function automatic logic [24:0] model(input int w, input int x, input int e);
    longint p, lim;
    logic [23:0] d;
    int nd;
    p = 1; d = '0;
    nd  = w ? 4 : 6;
    lim = w ? 10000 : 1000000;
    for (int i = 0; i < e; i++) if (p < lim) p = p * x;
    if (p >= lim) return w ? {1'b1, 24'h00EEEE} : {1'b1, 24'hEEEEEE};
    for (int i = 0; i < nd; i++) begin
      d[4*i +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return {1'b0, d};
  endfunction

  // Returns on the negedge just after the accepting edge T0.
  task automatic start_op(input int w, input int x, input int e);
    @(negedge clk);
    if (w == 0) begin b1.start = 1'b1; b1.operandX = 5'(x); b1.exponent = 3'(e); end
    else        begin b2.start = 1'b1; b2.operandX = 8'(x); b2.exponent = 3'(e); end
    @(negedge clk);
    b1.start = 1'b0; b2.start = 1'b0;
  endtask

  task automatic wait_done(input int w, input int n0, output int lat);
    lat = n0;
    while (!(w ? b2.done : b1.done) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input int w, input int x, input int e,
                     input logic [23:0] edig, input logic eov);
    int lat;
    start_op(w, x, e);
    wait_done(w, 0, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(e + (w ? 14 : 20)));
    chk({tag, "_dig"}, 64'(w ? {8'h0, b2.digits} : b1.digits), 64'(edig));
    chk({tag, "_ovf"}, 64'(w ? b2.overflow : b1.overflow), 64'(eov));
    chk({tag, "_busy0"}, 64'(w ? b2.busy : b1.busy), 64'(0));
    @(negedge clk);
    chk({tag, "_pulse1"}, 64'(w ? b2.done : b1.done), 64'(0));
  endtask

  initial begin
    logic [24:0] m;
    int lat, seen, x, e;
    b1.start = 1'b0; b1.operandX = '0; b1.exponent = '0; b1.hidden = 1'b0;
    b2.start = 1'b0; b2.operandX = '0; b2.exponent = '0; b2.hidden = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(b1.busy), 0);
    chk("rst_done", 64'(b1.done), 0);
    chk("rst_ovf",  64'(b1.overflow), 0);
    chk("rst_dig",  64'(b1.digits), 0);
    rst_n = 1'b1;

    run("x20e4", 0, 20, 4, 24'h160000, 1'b0);
    run("x31e4", 0, 31, 4, 24'h923521, 1'b0);
    run("x31e5", 0, 31, 5, 24'hEEEEEE, 1'b1);
    run("x0e0",  0, 0,  0, 24'h000001, 1'b0);
    run("x17e0", 0, 17, 0, 24'h000001, 1'b0);
    run("x0e3",  0, 0,  3, 24'h000000, 1'b0);

    // Blanking during and after an operation, then the true value reappears.
    b1.hidden = 1'b1;
    run("hid", 0, 20, 4, 24'hFFFFFF, 1'b0);
    chk("hid_ovf", 64'(b1.overflow), 0);
    b1.hidden = 1'b0;
    #1 chk("unhid_dig", 64'(b1.digits), 64'(24'h160000));

    // A start that arrives while the unit is busy is ignored.
    start_op(0, 20, 4);
    repeat (3) @(negedge clk);
    chk("ign_busy", 64'(b1.busy), 1);
    b1.start = 1'b1; b1.operandX = 5'd2; b1.exponent = 3'd1;
    @(negedge clk);
    b1.start = 1'b0;
    wait_done(0, 4, lat);
    chk("ign_lat", 64'(lat), 24);
    chk("ign_dig", 64'(b1.digits), 64'(24'h160000));
    @(negedge clk);

    // Reset asserted mid-conversion aborts the run.
    start_op(0, 31, 4);
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 64'(b1.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("ab_busy", 64'(b1.busy), 0);
    chk("ab_done", 64'(b1.done), 0);
    chk("ab_ovf",  64'(b1.overflow), 0);
    chk("ab_dig",  64'(b1.digits), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (b1.done) seen++; end
    chk("ab_nodone", 64'(seen), 0);

    // The second configuration: XW=8, DIGITS=4, RW=14.
    run("p_9e4",   1, 9,   4, 24'h006561, 1'b0);
    run("p_10e4",  1, 10,  4, 24'h00EEEE, 1'b1);
    run("p_255e1", 1, 255, 1, 24'h000255, 1'b0);
    run("p_0e0",   1, 0,   0, 24'h000001, 1'b0);

    // Random vectors against the reference model.
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom_range(0, 31)); e = int'($urandom_range(0, 7));
      m = model(0, x, e);
      run("rnd1", 0, x, e, m[23:0], m[24]);
      x = int'($urandom_range(0, 255)); e = int'($urandom_range(0, 7));
      m = model(1, x, e);
      run("rnd2", 1, x, e, m[23:0], m[24]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/power_bcd_unit.md
# power_bcd_unit

Sequential successor to the fixed 5-bit, six-digit operation block of the calculator datapath. It computes X^E for a parametrised operand width and a run-time exponent by iterative multiplication, then converts the result to a parametrised number of BCD digits with a serial double-dabble converter. A start/busy/done handshake controls it, and it has an overflow/error display mode and a live hide mask. It sits between the operand input stage and the 7-segment digit mux.

## Interface
Parameters:
- XW, 5, operand width in bits
- DIGITS, 6, number of BCD output digits
- RW, 20, binary result register width; must satisfy 2^RW ≥ 10^DIGITS
- EW, 3, exponent width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- operandX  in  XW  base X, unsigned; latched when start is accepted
- exponent  in  EW  exponent E, unsigned; latched when start is accepted
- hidden  in  1  live blanking mask
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- overflow  out  1  last result ≥ 10^DIGITS; sticky until next accepted start
- digits  out  4*DIGITS  BCD digits; digit i (i=0 is ones) at [4i+3:4i]

## Operation
- FSM states:
  - IDLE: waits for start. When start is sampled, X and E are latched, acc=1 and ovf=0, busy is set, and overflow is cleared. Next state is MUL if E>0, else CONV.
  - MUL: each cycle computes product = acc × X in RW+XW bits.
    - If product ≥ 10^DIGITS, set ovf and hold acc.
    - Otherwise acc ← product[RW-1:0].
    - Once ovf is set, acc stays frozen.
    - MUL lasts exactly E cycles, then goes to CONV.
  - CONV: serial double-dabble over acc, MSB first, one bit per cycle, for exactly RW cycles.
    - Each cycle, every BCD nibble ≥ 5 gets +3 before the shift.
    - CONV runs even when ovf=1; its result is discarded.
  - DONE: one cycle. This state:
    - loads the digits register with the BCD result, or with 4'hE in every digit if ovf;
    - copies ovf to overflow;
    - pulses done=1 and drops busy;
    - returns to IDLE.
- hidden=1 forces every output digit to 4'hF combinationally. hidden does not affect the internal register, the FSM, busy, done or overflow.
- start while busy (MUL/CONV/DONE) is ignored; no queueing.
- Digit register holds its last value between operations.
- E=0 yields 1 for any X, including X=0.
- X=0 with E>0 yields 0.

## Timing
- Reset values: busy=0, done=0, overflow=0, digits=all 0, FSM=IDLE, acc=0.
- rst_n asserted mid-operation aborts immediately to the reset values. No done pulse is issued.
- Let edge T0 be the edge that samples start.
  - busy is high from T0 until the edge that enters DONE.
  - DONE is entered at edge T0+E+RW.
  - done and the new digits/overflow are visible in the cycle after edge T0+E+RW.
  - busy=0 in that same cycle.
- Latency is independent of X and of overflow.
- A new start is accepted no earlier than the cycle after done is high.
- A start held high continuously is accepted again on the first IDLE cycle.

## Test plan
- X=20, E=4, hidden=0: digits=1,6,0,0,0,0 (MS→LS), overflow=0; done exactly E+RW=24 cycles after the start edge; done one cycle wide.
- X=31, E=4: digits=9,2,3,5,2,1, overflow=0. Then X=31, E=5 (28629151): overflow=1, all digits=4'hE, same 25-cycle latency.
- E=0 with X=0 and with X=17: digits=0,0,0,0,0,1 after 20 cycles. X=0, E=3: all zeros.
- hidden toggled during and after an operation: outputs are all 4'hF while hidden=1; the true result reappears when hidden=0; busy, done and overflow are unchanged.
- Sequence:
  - Start X=20 E=4.
  - Pulse start with X=2 E=1 while busy: ignored, result still 160000.
  - Pulse rst_n low during CONV of a second run: busy, done, overflow and digits are 0 immediately; no done pulse follows.
- Randomised X in 0..31, E in 0..7 against a reference model for overflow and digits, with a parameter sweep over XW=8, DIGITS=4, RW=14.
